pwm_gen_multi: RTL and testbench

//  NUM_CH-channel PWM generator; each channel has its own period (2^a*5^b ticks), duty (0..100 %) and alignment mode.

---
 rtl/pwm_gen_multi.sv | 164 ++++++++++++++++
 tb/tb_pwm_gen_multi.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_gen_multi
// Brief    : Multi-channel PWM generator with a shared tick prescaler,
//            per-channel shadowed configuration (valid/ready write port),
//            edge- or centre-aligned pulses and a global phase resync.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_gen_multi #(
  parameter int   CLK_FREQ = 50_000_000,
  parameter int   REF_FREQ = 50_000,
  parameter int   NUM_CH   = 4,
  parameter int   CNT_W    = 10,
  localparam int  CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync_start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_pow2,
  input  logic [1:0]        cfg_pow5,
  input  logic [6:0]        cfg_duty,
  input  logic              cfg_center,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] cycle_done
);

  localparam int              TICK_DIV = CLK_FREQ / REF_FREQ;
  localparam int              PS_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICK_DIV - 1);
  // Wide enough for N*duty + 99 with N < 2^CNT_W and duty <= 127
  localparam int              PW       = CNT_W + 7;

  logic [PS_W-1:0]   r_ps;
  logic              w_tick;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_pending;
  logic              w_wr;

  // A resync swallows the tick that would otherwise fire in the same clock
  assign w_tick = (r_ps == PS_LAST) & ~sync_start;

  // Shared prescaler: free-running 0..TICK_DIV-1, restarted by sync_start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ps <= '0;
    end else if (sync_start || (r_ps == PS_LAST)) begin
      r_ps <= '0;
    end else begin
      r_ps <= r_ps + 1'b1;
    end
  end

  // Ready only looks at the addressed channel; out-of-range channels match no
  // select bit, so they are always ready and the write is simply dropped.
  assign cfg_ready = ~|(w_sel & w_pending);
  assign w_wr      = cfg_valid & cfg_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       r_act_pow2, r_act_pow5, r_sh_pow2, r_sh_pow5;
    logic [6:0]       r_act_duty, r_sh_duty;
    logic             r_act_center, r_sh_center;
    logic             r_pend;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pwm;
    logic [CNT_W-1:0] w_p5;
    logic [CNT_W-1:0] w_n;
    logic [PW-1:0]    w_prod, w_p, w_s, w_cnt_x;
    logic             w_done;
    logic             w_high;

    assign w_sel[i]     = (cfg_ch == CH_W'(i));
    assign w_pending[i] = r_pend;

    // Period length N = 5^pow5 << pow2 from the active config
    always_comb begin
      w_p5 = CNT_W'(1);
      case (r_act_pow5)
        2'd0:    w_p5 = CNT_W'(1);
        2'd1:    w_p5 = CNT_W'(5);
        2'd2:    w_p5 = CNT_W'(25);
        default: w_p5 = CNT_W'(125);
      endcase
    end
    assign w_n = w_p5 << r_act_pow2;

    assign w_done        = w_tick & (r_cnt >= (w_n - 1'b1));
    assign cycle_done[i] = w_done;

    // Pulse width rounded up, and centre offset for centre-aligned mode
    assign w_prod  = (PW'(w_n) * PW'(r_act_duty)) + PW'(99);
    assign w_p     = w_prod / PW'(100);
    assign w_s     = (PW'(w_n) - w_p) >> 1;
    assign w_cnt_x = PW'(r_cnt);

    // Output level for the current period position
    always_comb begin
      if (r_act_duty == 7'd0) begin
        w_high = 1'b0;
      end else if (r_act_duty >= 7'd100) begin
        w_high = 1'b1;
      end else if (r_act_center) begin
        w_high = (w_cnt_x >= w_s) && (w_cnt_x < (w_s + w_p));
      end else begin
        w_high = (w_cnt_x < w_p);
      end
    end

    // Period counter: advances on tick, wraps at N-1, cleared by resync
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (sync_start) begin
        r_cnt <= '0;
      end else if (w_tick) begin
        r_cnt <= (r_cnt >= (w_n - 1'b1)) ? '0 : r_cnt + 1'b1;
      end
    end

    // Shadow/active config: shadow promoted only at the end of a period, so
    // the active config never changes mid-period. A write can only be taken
    // while nothing is pending, so it never collides with a promotion.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_act_pow2   <= '0;
        r_act_pow5   <= '0;
        r_act_duty   <= '0;
        r_act_center <= 1'b0;
        r_sh_pow2    <= '0;
        r_sh_pow5    <= '0;
        r_sh_duty    <= '0;
        r_sh_center  <= 1'b0;
        r_pend       <= 1'b0;
      end else if (w_done && r_pend) begin
        r_act_pow2   <= r_sh_pow2;
        r_act_pow5   <= r_sh_pow5;
        r_act_duty   <= r_sh_duty;
        r_act_center <= r_sh_center;
        r_pend       <= 1'b0;
      end else if (w_wr && w_sel[i]) begin
        r_sh_pow2    <= cfg_pow2;
        r_sh_pow5    <= cfg_pow5;
        r_sh_duty    <= (cfg_duty > 7'd100) ? 7'd100 : cfg_duty;
        r_sh_center  <= cfg_center;
        r_pend       <= 1'b1;
      end
    end

    // Registered pin driver; asynchronous reset forces it low immediately
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pwm <= 1'b0;
      end else begin
        r_pwm <= w_high;
      end
    end

    assign pwm_out[i] = r_pwm;
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_gen_multi
// Brief    : Self-checking bench for pwm_gen_multi (tick every 10 clk, 4 ch).
//            Expected per-cycle outputs come from a timeline model of the
//            configured epochs and are queued, then popped cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_gen_multi;

  logic       clk = 1'b0;
  logic       rst_n, sync_start, cfg_valid, cfg_ready, cfg_center;
  logic [1:0] cfg_ch, cfg_pow2, cfg_pow5;
  logic [6:0] cfg_duty;
  logic [3:0] pwm_out, cycle_done;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pwm_gen_multi #(
    .CLK_FREQ (1000),
    .REF_FREQ (100),
    .NUM_CH   (4),
    .CNT_W    (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_start (sync_start),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_pow2   (cfg_pow2),
    .cfg_pow5   (cfg_pow5),
    .cfg_duty   (cfg_duty),
    .cfg_center (cfg_center),
    .pwm_out    (pwm_out),
    .cycle_done (cycle_done)
  );

  // One configuration epoch: period N, duty, alignment, first cycle in force
  typedef struct packed { int n; int duty; bit cen; int a; } cfg_t;
  typedef struct packed { logic [3:0] pwm; logic [3:0] done; } exp_t;

  cfg_t ep [4][4];
  int   nep [4];
  exp_t sb [$];

  function automatic void model_clear();
    for (int c = 0; c < 4; c++) begin
      ep[c][0] = '{n: 1, duty: 0, cen: 1'b0, a: 0};
      nep[c]   = 1;
    end
  endfunction

  function automatic void model_add(int ch, int n, int duty, bit cen, int a);
    ep[ch][nep[ch]] = '{n: n, duty: (duty > 100) ? 100 : duty, cen: cen, a: a};
    nep[ch]++;
  endfunction

  function automatic cfg_t cfg_at(int ch, int k);
    cfg_t r = ep[ch][0];
    for (int e = 1; e < nep[ch]; e++) if (ep[ch][e].a <= k) r = ep[ch][e];
    return r;
  endfunction

  // Cycle k counted from the first clock after a resync; ticks at k%10==9
  function automatic int cnt_at(int ch, int k);
    cfg_t c = cfg_at(ch, k);
    return ((k - c.a) / 10) % c.n;
  endfunction

  function automatic bit level(cfg_t c, int cnt);
    int p, s;
    if (c.duty == 0)   return 1'b0;
    if (c.duty >= 100) return 1'b1;
    p = (c.n * c.duty + 99) / 100;
    if (!c.cen) return (cnt < p);
    s = (c.n - p) / 2;
    return (cnt >= s) && (cnt <= s + p - 1);
  endfunction

  function automatic exp_t mk_exp(int k);
    exp_t x;
    x = '0;
    for (int ch = 0; ch < 4; ch++) begin
      cfg_t c = cfg_at(ch, k);
      x.pwm[ch]  = (k == 0) ? 1'b0 : level(cfg_at(ch, k - 1), cnt_at(ch, k - 1));
      x.done[ch] = ((k % 10) == 9) && (cnt_at(ch, k) == c.n - 1);
    end
    return x;
  endfunction

  task automatic idle();
    sync_start = 1'b0;
    cfg_valid  = 1'b0;
  endtask

  task automatic set_wr(int ch, int p2, int p5, int duty, bit cen);
    cfg_valid  = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_pow2   = 2'(p2);
    cfg_pow5   = 2'(p5);
    cfg_duty   = 7'(duty);
    cfg_center = cen;
  endtask

  // Reset, release, then one sync_start pulse; the next negedge is cycle 0
  task automatic restart();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sync_start = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== 4'b0000) begin
      fails++; $display("FAIL reset_pwm got=%b exp=0000", pwm_out);
    end
    checks++;
    if (cycle_done !== 4'b0000) begin
      fails++; $display("FAIL reset_done got=%b exp=0000", cycle_done);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready got=%b exp=1", cfg_ready);
    end
    restart();
    for (int k = 0; k <= 35; k++) sb.push_back(mk_exp(k));
    for (int k = 0; k <= 35; k++) begin
      @(negedge clk);
      idle();
      #1;
      e = sb.pop_front();
      checks++;
      if (pwm_out !== e.pwm || cycle_done !== e.done) begin
        fails++;
        $display("FAIL idle k=%0d pwm=%b done=%b exp pwm=%b done=%b", k, pwm_out, cycle_done, e.pwm, e.done);
      end
      checks++;
      if (cfg_ready !== 1'b1) begin
        fails++; $display("FAIL idle_ready k=%0d got=%b exp=1", k, cfg_ready);
      end
    end
  endtask

  task automatic test_edge();
    exp_t e;
    restart();
    model_add(0, 4, 50, 1'b0, 10);
    model_add(0, 4, 127, 1'b0, 50);
    for (int k = 0; k <= 100; k++) sb.push_back(mk_exp(k));
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      idle();
      if (k == 0)  set_wr(0, 2, 0, 50, 1'b0);
      if (k == 10) set_wr(0, 2, 0, 127, 1'b0);
      #1;
      e = sb.pop_front();
      checks++;
      if (pwm_out !== e.pwm || cycle_done !== e.done) begin
        fails++;
        $display("FAIL edge k=%0d pwm=%b done=%b exp pwm=%b done=%b", k, pwm_out, cycle_done, e.pwm, e.done);
      end
      if (k == 0 || k == 10) begin
        checks++;
        if (cfg_ready !== 1'b1) begin
          fails++; $display("FAIL edge_ready k=%0d got=%b exp=1", k, cfg_ready);
        end
      end
    end
  endtask

  task automatic test_center();
    exp_t e;
    restart();
    model_add(0, 4, 50, 1'b1, 10);
    model_add(0, 4, 33, 1'b1, 50);
    model_add(0, 4, 100, 1'b1, 90);
    for (int k = 0; k <= 130; k++) sb.push_back(mk_exp(k));
    for (int k = 0; k <= 130; k++) begin
      @(negedge clk);
      idle();
      if (k == 0)  set_wr(0, 2, 0, 50, 1'b1);
      if (k == 10) set_wr(0, 2, 0, 33, 1'b1);
      if (k == 50) set_wr(0, 2, 0, 100, 1'b1);
      #1;
      e = sb.pop_front();
      checks++;
      if (pwm_out !== e.pwm || cycle_done !== e.done) begin
        fails++;
        $display("FAIL center k=%0d pwm=%b done=%b exp pwm=%b done=%b", k, pwm_out, cycle_done, e.pwm, e.done);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic exp_rdy;
    restart();
    model_add(1, 2, 50, 1'b0, 10);
    model_add(1, 5, 40, 1'b1, 30);
    model_add(2, 8, 25, 1'b0, 10);
    for (int k = 0; k <= 100; k++) sb.push_back(mk_exp(k));
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      idle();
      if (k == 0)              set_wr(1, 1, 0, 50, 1'b0);
      if (k == 1)              set_wr(1, 0, 1, 40, 1'b1);
      if (k == 2)              set_wr(2, 3, 0, 25, 1'b0);
      if (k >= 3 && k <= 10)   set_wr(1, 0, 1, 40, 1'b1);
      #1;
      e = sb.pop_front();
      checks++;
      if (pwm_out !== e.pwm || cycle_done !== e.done) begin
        fails++;
        $display("FAIL b2b k=%0d pwm=%b done=%b exp pwm=%b done=%b", k, pwm_out, cycle_done, e.pwm, e.done);
      end
      if (k <= 10) begin
        exp_rdy = (k == 0 || k == 2 || k == 10);
        checks++;
        if (cfg_ready !== exp_rdy) begin
          fails++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, cfg_ready, exp_rdy);
        end
      end
    end
  endtask

  task automatic test_same_clk();
    exp_t e;
    restart();
    model_add(3, 2, 50, 1'b0, 10);
    model_add(3, 4, 75, 1'b1, 50);
    for (int k = 0; k <= 100; k++) sb.push_back(mk_exp(k));
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      idle();
      if (k == 0)  set_wr(3, 1, 0, 50, 1'b0);
      if (k == 29) set_wr(3, 2, 0, 75, 1'b1);
      #1;
      e = sb.pop_front();
      checks++;
      if (pwm_out !== e.pwm || cycle_done !== e.done) begin
        fails++;
        $display("FAIL same_clk k=%0d pwm=%b done=%b exp pwm=%b done=%b", k, pwm_out, cycle_done, e.pwm, e.done);
      end
      if (k == 29) begin
        checks++;
        if (cfg_ready !== 1'b1 || cycle_done[3] !== 1'b1) begin
          fails++; $display("FAIL same_clk_wr ready=%b done3=%b exp 1 1", cfg_ready, cycle_done[3]);
        end
      end
    end
  endtask

  task automatic test_sync();
    exp_t e;
    exp_t e_sync;
    exp_t e_first;
    // Phase A: configure ch0 N=8 and ch1 N=25, resync mid-period at k=24
    restart();
    model_add(0, 8, 50, 1'b0, 10);
    model_add(1, 25, 20, 1'b1, 10);
    for (int k = 0; k <= 24; k++) sb.push_back(mk_exp(k));
    e_first = mk_exp(25);
    for (int k = 0; k <= 24; k++) begin
      @(negedge clk);
      idle();
      if (k == 0)  set_wr(0, 3, 0, 50, 1'b0);
      if (k == 1)  set_wr(1, 0, 2, 20, 1'b1);
      if (k == 24) sync_start = 1'b1;
      #1;
      e = sb.pop_front();
      checks++;
      if (pwm_out !== e.pwm || cycle_done !== e.done) begin
        fails++;
        $display("FAIL sync_a k=%0d pwm=%b done=%b exp pwm=%b done=%b", k, pwm_out, cycle_done, e.pwm, e.done);
      end
    end
    // Phase B: counters restart from 0; second resync lands on a tick cycle
    model_clear();
    model_add(0, 8, 50, 1'b0, 0);
    model_add(1, 25, 20, 1'b1, 0);
    e_first.done = 4'b0000;
    sb.push_back(e_first);
    for (int k = 1; k <= 19; k++) sb.push_back(mk_exp(k));
    e_sync      = mk_exp(20);
    e_first.pwm = e_sync.pwm;
    for (int k = 0; k <= 19; k++) begin
      @(negedge clk);
      idle();
      if (k == 19) sync_start = 1'b1;
      #1;
      e = sb.pop_front();
      if (k == 19) e.done = 4'b0000;
      checks++;
      if (pwm_out !== e.pwm || cycle_done !== e.done) begin
        fails++;
        $display("FAIL sync_b k=%0d pwm=%b done=%b exp pwm=%b done=%b", k, pwm_out, cycle_done, e.pwm, e.done);
      end
    end
    // Phase C: after the second resync, then an asynchronous reset mid-pulse
    sb.push_back(e_first);
    for (int k = 1; k <= 5; k++) sb.push_back(mk_exp(k));
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      idle();
      #1;
      e = sb.pop_front();
      checks++;
      if (pwm_out !== e.pwm || cycle_done !== e.done) begin
        fails++;
        $display("FAIL sync_c k=%0d pwm=%b done=%b exp pwm=%b done=%b", k, pwm_out, cycle_done, e.pwm, e.done);
      end
    end
    checks++;
    if (pwm_out[0] !== 1'b1) begin
      fails++; $display("FAIL pre_rst_pulse got=%b exp=1", pwm_out[0]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== 4'b0000 || cycle_done !== 4'b0000) begin
      fails++; $display("FAIL async_rst pwm=%b done=%b exp 0000 0000", pwm_out, cycle_done);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    sync_start = 1'b0;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_pow2   = '0;
    cfg_pow5   = '0;
    cfg_duty   = '0;
    cfg_center = 1'b0;
    model_clear();
    test_reset();
    test_edge();
    test_center();
    test_back_to_back();
    test_same_clk();
    test_sync();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
